if_fetch_stage_16bit: RTL and testbench
=======================================

// Module: if_fetch_stage_16bit
// PURPOSE
//   16-bit MIPS instruction-fetch stage: holds the PC, runs the instruction-memory request/ready
//   handshake and loads the IF/ID pipeline register. It sits directly downstream of the PC-select
//   16-bit 2:1 mux. It drives that mux's a input (pc_plus). The mux's s input is branch_taken and
//   its output is pc_next_in. The mux enable is tied high at top level.
// PARAMETERS
//   RESET_PC   16'h0000   PC value loaded on reset
//   PC_STEP    2          sequential increment (bytes per 16-bit instruction)
// PORTS
//   clk           in   1   single clock, rising edge
//   rst_n         in   1   asynchronous, active-low reset
//   pc_next_in    in   16  PC-select mux output: pc_plus when branch_taken=0, branch target when 1
//   branch_taken  in   1   redirect from EX; same net as the mux select
//   stall         in   1   hazard unit: hold IF/ID and PC
//   imem_rdy      in   1   instruction memory: imem_instr valid this cycle
//   imem_instr    in   16  instruction word returned by memory
//   imem_req      out  1   fetch request; level, held until imem_rdy
//   imem_addr     out  16  fetch address; stable while imem_req=1 and imem_rdy=0
//   pc            out  16  current PC register
//   pc_plus       out  16  pc + PC_STEP, mod 2^16 (combinational); drives mux input a
//   ifid_instr    out  16  IF/ID instruction register
//   ifid_pc_plus  out  16  IF/ID copy of pc_plus for the fetched instruction
//   ifid_valid    out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ifid_instr=0, ifid_pc_plus=0, ifid_valid=0,
//     buf=0, drain_addr=0; imem_req=0. Reset asserted mid-operation aborts everything. Any late
//     imem_rdy for an aborted request is ignored.
//   States: IDLE, FETCH, HOLD, DRAIN.
//     - imem_req=1 in FETCH and DRAIN only.
//     - imem_addr = pc in FETCH and drain_addr in DRAIN.
//   IDLE: go to FETCH on the next clk unconditionally.
//   Precedence in every state: branch_taken > stall > normal.
//   FETCH:
//     - branch_taken=1: pc<=pc_next_in and ifid_valid<=0.
//       - If imem_rdy=1, the returned data is discarded and the state stays FETCH.
//       - If imem_rdy=0: drain_addr<=pc, go to DRAIN.
//     - imem_rdy=1, stall=0: ifid_instr<=imem_instr, ifid_pc_plus<=pc_plus, ifid_valid<=1,
//       pc<=pc_next_in; stay in FETCH. Zero-wait memory gives 1 instruction/cycle.
//     - imem_rdy=1, stall=1: buf<=imem_instr, go to HOLD. PC and IF/ID unchanged.
//     - imem_rdy=0, stall=0: ifid_valid<=0 (bubble). imem_rdy=0, stall=1: IF/ID holds.
//   HOLD (imem_req=0, one buffered instruction):
//     - stall=1: everything holds.
//     - stall=0: IF/ID <= {buf, pc_plus, valid=1}, pc<=pc_next_in, go to FETCH.
//     - branch_taken=1: drop buf, pc<=pc_next_in, ifid_valid<=0, go to FETCH.
//   DRAIN (stale request outstanding; imem_addr held at drain_addr):
//     - imem_rdy=1: discard the data, go to FETCH (which fetches the new pc).
//     - branch_taken=1 in DRAIN: pc<=pc_next_in again, stay in DRAIN.
//     - stall is ignored in DRAIN. IF/ID holds except that ifid_valid is cleared.
//   Width: all PC arithmetic is 16-bit unsigned with wrap. pc=16'hFFFE gives pc_plus=16'h0000.
//   One memory request is outstanding at most. imem_req never drops before imem_rdy.
// TESTING
//   1 Release reset, imem_rdy=1, imem_instr=16'hA000+addr
//     -> imem_req rises 1 cycle after IDLE; imem_addr 0000,0002,0004...;
//     -> ifid_instr A000,A002... with ifid_pc_plus 0002,0004..., ifid_valid=1 every cycle.
//   2 At pc=0004 hold imem_rdy=0 for 3 cycles
//     -> imem_addr stays 0004, ifid_valid=0 for 3 cycles, then ifid_instr=A004.
//   3 stall=1 for 2 cycles as imem_rdy returns 16'hB00B
//     -> HOLD, imem_req=0, IF/ID unchanged; stall drop -> ifid_instr=B00B, pc advances by 2.
//   4 At pc=0008 with imem_rdy=0, pulse branch_taken with pc_next_in=0100
//     -> DRAIN, imem_addr=0008 until rdy, data dropped; next imem_addr=0100, ifid_valid=0 meanwhile.
//   5 Branch to FFFE
//     -> pc_plus=0000; next sequential imem_addr=0000 (wrap).
//   6 Assert rst_n=0 during DRAIN
//     -> immediately pc=0000, imem_req=0, ifid_valid=0; restart as in test 1.

Source files
------------

// File: rtl/if_fetch_stage_16bit.sv
// Instruction-fetch stage for a 16-bit MIPS pipeline: PC register, imem request/ready
// handshake and IF/ID register, with one-entry stall buffer and stale-request draining.
//
// state | meaning
// IDLE  | post-reset, no request issued yet
// FETCH | request at pc outstanding
// HOLD  | instruction returned during stall, parked in hold_buf
// DRAIN | waiting out a request to an abandoned address
module if_fetch_stage_16bit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_next_in,
  input  logic        branch_taken,
  input  logic        stall,
  input  logic        imem_rdy,
  input  logic [15:0] imem_instr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] pc,
  output logic [15:0] pc_plus,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_nx;
  logic [15:0] pc_nx, ifid_instr_nx, ifid_pc_plus_nx;
  logic        ifid_valid_nx;
  logic [15:0] hold_buf, hold_buf_nx;
  logic [15:0] drain_addr, drain_addr_nx;

  assign pc_plus   = pc + PC_STEP;
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ifid_instr   <= 16'h0000;
      ifid_pc_plus <= 16'h0000;
      ifid_valid   <= 1'b0;
      hold_buf     <= 16'h0000;
      drain_addr   <= 16'h0000;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      ifid_instr   <= ifid_instr_nx;
      ifid_pc_plus <= ifid_pc_plus_nx;
      ifid_valid   <= ifid_valid_nx;
      hold_buf     <= hold_buf_nx;
      drain_addr   <= drain_addr_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    pc_nx           = pc;
    ifid_instr_nx   = ifid_instr;
    ifid_pc_plus_nx = ifid_pc_plus;
    ifid_valid_nx   = ifid_valid;
    hold_buf_nx     = hold_buf;
    drain_addr_nx   = drain_addr;
    unique case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        if (branch_taken) begin
          pc_nx         = pc_next_in;
          ifid_valid_nx = 1'b0;
          // data already in flight for the old pc must be absorbed before refetching
          if (!imem_rdy) begin
            drain_addr_nx = pc;
            state_nx      = DRAIN;
          end
        end else if (imem_rdy && !stall) begin
          ifid_instr_nx   = imem_instr;
          ifid_pc_plus_nx = pc_plus;
          ifid_valid_nx   = 1'b1;
          pc_nx           = pc_next_in;
        end else if (imem_rdy) begin
          hold_buf_nx = imem_instr;
          state_nx    = HOLD;
        end else if (!stall) begin
          ifid_valid_nx = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_nx         = pc_next_in;
          ifid_valid_nx = 1'b0;
          state_nx      = FETCH;
        end else if (!stall) begin
          ifid_instr_nx   = hold_buf;
          ifid_pc_plus_nx = pc_plus;
          ifid_valid_nx   = 1'b1;
          pc_nx           = pc_next_in;
          state_nx        = FETCH;
        end
      end
      DRAIN: begin
        ifid_valid_nx = 1'b0;
        if (branch_taken) pc_nx = pc_next_in;
        if (imem_rdy) state_nx = FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage_16bit.sv
// Directed bench for if_fetch_stage_16bit: expected fetch addresses and IF/ID loads are
// queued by the stimulus and consumed by a monitor; a few state checks are made inline.
module tb_if_fetch_stage_16bit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_next_in;
  logic        branch_taken;
  logic        stall;
  logic        imem_rdy;
  logic [15:0] imem_instr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus;
  logic        ifid_valid;

  logic [15:0] br_target;
  logic        ovr_en;

  int total  = 0;
  int passed = 0;

  logic [15:0] exp_addr[$];
  logic [31:0] exp_ifid[$];

  always #5 clk = ~clk;

  // external PC-select mux and memory model
  assign pc_next_in = branch_taken ? br_target : pc_plus;
  assign imem_instr = ovr_en ? 16'hB00B : 16'hA000 + imem_addr;

  if_fetch_stage_16bit dut (
    .clk(clk), .rst_n(rst_n), .pc_next_in(pc_next_in), .branch_taken(branch_taken),
    .stall(stall), .imem_rdy(imem_rdy), .imem_instr(imem_instr), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc(pc), .pc_plus(pc_plus), .ifid_instr(ifid_instr),
    .ifid_pc_plus(ifid_pc_plus), .ifid_valid(ifid_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: handshakes and IF/ID loads (a load follows an edge taken with stall=0)
  initial begin
    logic load_flag;
    logic [15:0] ea;
    logic [31:0] ei;
    load_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ifid_valid && load_flag) begin
        if (exp_ifid.size() == 0) check("ifid_unexpected", {ifid_instr, ifid_pc_plus}, 32'hxxxxxxxx);
        else begin
          ei = exp_ifid.pop_front();
          check("ifid_load", {ifid_instr, ifid_pc_plus}, ei);
        end
      end
      if (rst_n && imem_req && imem_rdy) begin
        if (exp_addr.size() == 0) check("addr_unexpected", {16'h0, imem_addr}, 32'hxxxxxxxx);
        else begin
          ea = exp_addr.pop_front();
          check("fetch_addr", {16'h0, imem_addr}, {16'h0, ea});
        end
      end
      load_flag = rst_n && !stall;
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; imem_rdy = 1'b1;
    br_target = 16'h0000; ovr_en = 1'b0;
    step(2);
    check("rst_pc", {16'h0, pc}, 32'h0000);
    check("rst_ifid_instr", {16'h0, ifid_instr}, 32'h0000);
    check("rst_ifid_pc_plus", {16'h0, ifid_pc_plus}, 32'h0000);
    check("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_pc_plus", {16'h0, pc_plus}, 32'h0002);

    // test 1: zero-wait streaming
    rst_n = 1'b1;
    exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0002);
    exp_ifid.push_back({16'hA000, 16'h0002}); exp_ifid.push_back({16'hA002, 16'h0004});
    check("idle_req", {31'h0, imem_req}, 32'h0);
    step(1);
    check("fetch_req", {31'h0, imem_req}, 32'h1);
    check("fetch_addr0", {16'h0, imem_addr}, 32'h0000);
    step(2);
    check("pc_at_4", {16'h0, pc}, 32'h0004);

    // test 2: three wait cycles at 0004
    imem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("wait_bubble", {31'h0, ifid_valid}, 32'h0);
      check("wait_addr", {16'h0, imem_addr}, 32'h0004);
    end
    imem_rdy = 1'b1;
    exp_addr.push_back(16'h0004);
    exp_ifid.push_back({16'hA004, 16'h0006});
    step(1);

    // test 3: stall while B00B returns
    stall = 1'b1; ovr_en = 1'b1;
    exp_addr.push_back(16'h0006);
    step(1);
    ovr_en = 1'b0;
    check("hold_req", {31'h0, imem_req}, 32'h0);
    check("hold_ifid", {16'h0, ifid_instr}, 32'hA004);
    check("hold_pc", {16'h0, pc}, 32'h0006);
    step(1);
    stall = 1'b0;
    exp_ifid.push_back({16'hB00B, 16'h0008});
    step(1);
    check("hold_release_pc", {16'h0, pc}, 32'h0008);

    // test 4: branch to 0100 while request at 0008 is pending
    imem_rdy = 1'b0; branch_taken = 1'b1; br_target = 16'h0100;
    step(1);
    branch_taken = 1'b0;
    check("drain_addr", {16'h0, imem_addr}, 32'h0008);
    check("drain_req", {31'h0, imem_req}, 32'h1);
    check("drain_pc", {16'h0, pc}, 32'h0100);
    check("drain_valid", {31'h0, ifid_valid}, 32'h0);
    step(1);
    check("drain_addr_held", {16'h0, imem_addr}, 32'h0008);
    imem_rdy = 1'b1;
    exp_addr.push_back(16'h0008); exp_addr.push_back(16'h0100);
    exp_ifid.push_back({16'hA100, 16'h0102});
    step(1);
    check("drain_exit_valid", {31'h0, ifid_valid}, 32'h0);
    step(1);

    // test 5: branch to FFFE, wrap to 0000
    branch_taken = 1'b1; br_target = 16'hFFFE;
    exp_addr.push_back(16'h0102); exp_addr.push_back(16'hFFFE); exp_addr.push_back(16'h0000);
    exp_ifid.push_back({16'h9FFE, 16'h0000}); exp_ifid.push_back({16'hA000, 16'h0002});
    step(1);
    branch_taken = 1'b0;
    check("wrap_pc_plus", {16'h0, pc_plus}, 32'h0000);
    check("wrap_addr_fffe", {16'h0, imem_addr}, 32'hFFFE);
    step(1);
    check("wrap_addr_0000", {16'h0, imem_addr}, 32'h0000);
    step(1);

    // test 6: reset during DRAIN, late rdy ignored, restart
    imem_rdy = 1'b0; branch_taken = 1'b1; br_target = 16'h0200;
    step(1);
    branch_taken = 1'b0;
    check("pre_reset_drain", {16'h0, imem_addr}, 32'h0002);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", {16'h0, pc}, 32'h0000);
    check("async_rst_req", {31'h0, imem_req}, 32'h0);
    check("async_rst_valid", {31'h0, ifid_valid}, 32'h0);
    step(1);
    imem_rdy = 1'b1;
    step(1);
    rst_n = 1'b1;
    exp_addr.push_back(16'h0000); exp_addr.push_back(16'h0002);
    exp_ifid.push_back({16'hA000, 16'h0002}); exp_ifid.push_back({16'hA002, 16'h0004});
    step(1);
    check("restart_req", {31'h0, imem_req}, 32'h1);
    check("restart_addr", {16'h0, imem_addr}, 32'h0000);
    step(2);
    imem_rdy = 1'b0;
    step(2);
    check("addr_q_empty", exp_addr.size(), 32'd0);
    check("ifid_q_empty", exp_ifid.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
